// File: rtl/ae_pkg.sv
// Shared constants and types for the arithmetic-encoder output bit packer.
package ae_pkg;

    localparam int unsigned AE_IN_W    = 16;
    localparam int unsigned AE_OUT_W   = 32;
    localparam int unsigned AE_ACC_W   = 2 * AE_OUT_W;
    localparam int unsigned AE_CNT_W   = 7;
    localparam int unsigned AE_NBITS_W = 6;
    localparam int unsigned AE_LEN_W   = 5;

    typedef enum logic {
        StRun,
        StDrain
    } ae_pack_state_t;

endpackage

// File: rtl/ae_bit_packer_if.sv
// Input-group and output-word handshakes of the bit packer.
interface ae_bit_packer_if #(
    parameter int unsigned IN_W  = ae_pkg::AE_IN_W,
    parameter int unsigned OUT_W = ae_pkg::AE_OUT_W
);

    logic                            in_valid;
    logic                            in_ready;
    logic [IN_W-1:0]                 in_bits;
    logic [ae_pkg::AE_LEN_W-1:0]     in_len;
    logic                            flush;
    logic                            out_valid;
    logic                            out_ready;
    logic [OUT_W-1:0]                out_word;
    logic                            out_last;
    logic [ae_pkg::AE_NBITS_W-1:0]   out_nbits;

    // master: the surrounding encoder (group source and word sink); slave: the packer
    modport master (
        output in_valid, in_bits, in_len, flush, out_ready,
        input  in_ready, out_valid, out_word, out_last, out_nbits
    );

    modport slave (
        input  in_valid, in_bits, in_len, flush, out_ready,
        output in_ready, out_valid, out_word, out_last, out_nbits
    );

endinterface

// File: rtl/ae_bit_align.sv
// Aligns a right-justified bit group to the top of the accumulator field, then
// shifts it right by the current fill level through a logarithmic shifter.
module ae_bit_align import ae_pkg::*; #(
    parameter int unsigned IN_W  = AE_IN_W,
    parameter int unsigned ACC_W = AE_ACC_W
) (
    input  logic [IN_W-1:0]          bits,
    input  logic [AE_LEN_W-1:0]      len,
    input  logic [$clog2(ACC_W)-1:0] shift,
    output logic [ACC_W-1:0]         field
);

    localparam int unsigned SHW = $clog2(ACC_W);

    logic [IN_W-1:0]  aligned;
    logic [ACC_W-1:0] stage [SHW+1];

    // Left shift inside IN_W drops any junk above the meaningful len bits
    assign aligned  = bits << (AE_LEN_W'(IN_W) - len);
    assign stage[0] = {aligned, {(ACC_W - IN_W){1'b0}}};

    for (genvar i = 0; i < SHW; i++) begin : g_stage
        assign stage[i+1] = shift[i] ? (stage[i] >> (1 << i)) : stage[i];
    end

    assign field = stage[SHW];

endmodule

// File: rtl/ae_bit_packer.sv
// Packs variable-length bit groups MSB-first into 32-bit words, with a flush
// sequence that emits the zero-padded residual word tagged as last.
module ae_bit_packer import ae_pkg::*; #(
    parameter int unsigned IN_W  = AE_IN_W,
    parameter int unsigned OUT_W = AE_OUT_W
) (
    input  logic            clk,
    input  logic            rst,
    ae_bit_packer_if.slave  bus,
    output logic            len_err,
    output logic [31:0]     word_count
);

    localparam int unsigned ACC_W = 2 * OUT_W;
    localparam int unsigned CNT_W = $clog2(ACC_W + 1);
    localparam int unsigned SHW   = $clog2(ACC_W);

    ae_pack_state_t     state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               len_err_q, len_err_d;
    logic [31:0]        word_count_q, word_count_d;

    logic               in_ready_c, out_valid_c, out_last_c;
    logic               push, pop, len_over;
    logic [AE_LEN_W-1:0] len_eff;
    logic [ACC_W-1:0]   base_acc, field;
    logic [CNT_W-1:0]   base_cnt;

    // Outputs depend only on registered state, never on the current inputs
    always_comb begin
        in_ready_c  = (state_q == StRun) && (count_q <= CNT_W'(ACC_W - IN_W));
        out_valid_c = (state_q == StDrain) || (count_q >= CNT_W'(OUT_W));
        out_last_c  = (state_q == StDrain) && (count_q < CNT_W'(OUT_W));

        bus.in_ready  = in_ready_c;
        bus.out_valid = out_valid_c;
        bus.out_last  = out_last_c;
        bus.out_word  = acc_q[ACC_W-1 -: OUT_W];
        bus.out_nbits = '0;
        if (out_valid_c) begin
            bus.out_nbits = out_last_c ? count_q[AE_NBITS_W-1:0] : AE_NBITS_W'(OUT_W);
        end
    end

    assign push     = bus.in_valid && in_ready_c;
    assign pop      = out_valid_c && bus.out_ready;
    assign len_over = bus.in_len > AE_LEN_W'(IN_W);
    assign len_eff  = len_over ? AE_LEN_W'(IN_W) : bus.in_len;
    assign base_acc = pop ? (acc_q << OUT_W) : acc_q;
    assign base_cnt = pop ? (count_q - CNT_W'(OUT_W)) : count_q;

    ae_bit_align #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_align (
        .bits  (bus.in_bits),
        .len   (len_eff),
        .shift (base_cnt[SHW-1:0]),
        .field (field)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        len_err_d    = len_err_q;
        word_count_d = word_count_q;

        if (pop) begin
            word_count_d = word_count_q + 32'd1;
        end
        if (push && len_over) begin
            len_err_d = 1'b1;
        end

        unique case (state_q)
            StRun: begin
                acc_d   = push ? (base_acc | field) : base_acc;
                count_d = push ? (base_cnt + CNT_W'(len_eff)) : base_cnt;
                if (push && bus.flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && out_last_c) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = StRun;
                end else begin
                    acc_d   = base_acc;
                    count_d = base_cnt;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            acc_q        <= '0;
            count_q      <= '0;
            len_err_q    <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            len_err_q    <= len_err_d;
            word_count_q <= word_count_d;
        end
    end

    assign len_err    = len_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_ae_bit_packer.sv
// Directed bench for ae_bit_packer: a bit-level queue model predicts every word.
module tb_ae_bit_packer;
    import ae_pkg::*;

    typedef struct packed {
        logic [31:0] word;
        logic [5:0]  nbits;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        len_err;
    logic [31:0] word_count;

    int          n_asserts = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    bit          bitq[$];
    logic [31:0] last_word = '0;

    ae_bit_packer_if bus ();

    ae_bit_packer dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .len_err    (len_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: a plain bit queue, words cut off every 32 bits
    task automatic model_push(input logic [15:0] bits, input logic [4:0] len, input logic fl);
        int   l;
        exp_t e;
        l = (len > 5'd16) ? 16 : int'(len);
        for (int i = l - 1; i >= 0; i--) bitq.push_back(bits[i]);
        while (bitq.size() >= 32) begin
            e = '0;
            for (int i = 0; i < 32; i++) e.word[31-i] = bitq.pop_front();
            e.nbits = 6'd32;
            exp_q.push_back(e);
        end
        if (fl) begin
            e       = '0;
            e.nbits = 6'(bitq.size());
            e.last  = 1'b1;
            for (int i = 0; i < 32 && bitq.size() > 0; i++) e.word[31-i] = bitq.pop_front();
            exp_q.push_back(e);
        end
    endtask

    task automatic push(input logic [15:0] bits, input logic [4:0] len, input logic fl);
        bit ok = 0;
        bus.in_valid = 1'b1;
        bus.in_bits  = bits;
        bus.in_len   = len;
        bus.flush    = fl;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        if (ok) model_push(bits, len, fl);
        else check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        tick(1);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(bus.out_word), 64'hDEAD_0000_0000_0000);
            end else begin
                e = exp_q.pop_front();
                check("word", 64'(bus.out_word), 64'(e.word));
                check("nbits", 64'(bus.out_nbits), 64'(e.nbits));
                check("last", 64'(bus.out_last), 64'(e.last));
            end
            last_word = bus.out_word;
        end
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bits   = '0;
        bus.in_len    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        tick(2);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_word", 64'(bus.out_word), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_nbits", 64'(bus.out_nbits), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        tick(1);

        // Two full groups make one word, visible the cycle after the second accept
        bus.out_ready = 1'b1;
        push(16'hABCD, 5'd16, 1'b0);
        push(16'h1234, 5'd16, 1'b0);
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        wait_empty();
        check("w_abcd1234", 64'(last_word), 64'h0000_0000_ABCD_1234);
        check("empty_after_w1", 64'(bus.out_valid), 64'd0);
        check("wc1", 64'(word_count), 64'd1);

        // Seven 5-bit groups, residual 110 recovered by an empty flush group
        for (int i = 0; i < 7; i++) push(16'h0016, 5'd5, 1'b0);
        wait_empty();
        check("w_b5ad6b5a", 64'(last_word), 64'h0000_0000_B5AD_6B5A);
        check("residual_not_valid", 64'(bus.out_valid), 64'd0);
        push(16'h0000, 5'd0, 1'b1);
        check("drain_first_valid", 64'(bus.out_valid), 64'd1);
        check("drain_in_ready", 64'(bus.in_ready), 64'd0);
        wait_empty();
        check("w_residual", 64'(last_word), 64'h0000_0000_C000_0000);
        check("run_after_drain", 64'(bus.in_ready), 64'd1);
        check("wc3", 64'(word_count), 64'd3);

        // Back-pressure: fill to 64 bits, then hold and release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(16'hFFFF, 5'd16, 1'b0);
        tick(1);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        tick(3);
        check("stall_hold_word", 64'(bus.out_word), 64'h0000_0000_FFFF_FFFF);
        check("stall_hold_nbits", 64'(bus.out_nbits), 64'd32);
        bus.out_ready = 1'b1;
        wait_empty();
        check("wc5", 64'(word_count), 64'd5);

        // Flush of a short group, then flush with nothing buffered
        push(16'h0005, 5'd3, 1'b1);
        wait_empty();
        check("w_a0000000", 64'(last_word), 64'h0000_0000_A000_0000);
        check("run_after_flush", 64'(bus.in_ready), 64'd1);
        push(16'h0000, 5'd0, 1'b1);
        wait_empty();
        check("w_terminator", 64'(last_word), 64'd0);
        check("wc7", 64'(word_count), 64'd7);

        // Over-long length is clamped and sticks in len_err
        push(16'hFFFF, 5'd20, 1'b0);
        check("len_err_set", 64'(len_err), 64'd1);
        push(16'h0F0F, 5'd16, 1'b0);
        push(16'hFFF3, 5'd4, 1'b1);
        wait_empty();
        check("len_err_sticky", 64'(len_err), 64'd1);
        check("w_masked", 64'(last_word), 64'h0000_0000_3000_0000);
        check("wc9", 64'(word_count), 64'd9);

        // Reset in DRAIN with 40 bits buffered discards everything
        bus.out_ready = 1'b0;
        push(16'h1234, 5'd16, 1'b0);
        push(16'h5678, 5'd16, 1'b0);
        push(16'h00AB, 5'd8, 1'b1);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        bitq.delete();
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_word", 64'(bus.out_word), 64'd0);
        check("mid_rst_out_last", 64'(bus.out_last), 64'd0);
        check("mid_rst_out_nbits", 64'(bus.out_nbits), 64'd0);
        check("mid_rst_len_err", 64'(len_err), 64'd0);
        check("mid_rst_word_count", 64'(word_count), 64'd0);
        tick(1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick(4);
        check("post_rst_no_word", 64'(bus.out_valid), 64'd0);
        check("post_rst_wc", 64'(word_count), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
